uart_rx: RTL



---
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver
//
// Synchronises the raw serial line, checks the start bit at mid-bit, samples
// eight data bits LSB-first at bit centres and checks the stop bit. Each good
// byte is presented on rx_data with a one-cycle rx_valid strobe. A low stop
// bit gives a one-cycle rx_frame_err strobe and leaves rx_data untouched.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   rx_in         raw serial line (idle high, asynchronous to clk)
//   rx_data[7:0]  last correctly received byte, held until the next good byte
//   rx_valid      one-cycle pulse, rx_data updated this cycle
//   rx_frame_err  one-cycle pulse, stop bit sampled low
//   rx_busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [15:0] LP_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LP_HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Two-flop synchroniser; all receive decisions look at w_rx_s only.
  logic r_sync1;
  logic r_sync2;
  logic w_rx_s;

  state_t      r_state;
  logic [15:0] r_clk_count;
  logic [2:0]  r_bit_index;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;

  state_t      w_state_next;
  logic [15:0] w_clk_count_next;
  logic [2:0]  w_bit_index_next;
  logic [7:0]  w_shift_next;
  logic [7:0]  w_data_next;
  logic        w_valid_next;
  logic        w_frame_err_next;

  assign w_rx_s = r_sync2;

  // Synchroniser flops reset to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops capture the values
      // from before this edge, giving a true two-stage pipeline.
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_clk_count <= '0;
      r_bit_index <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clk_count <= w_clk_count_next;
      r_bit_index <= w_bit_index_next;
      r_shift     <= w_shift_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // the block leaves one unassigned, which would otherwise infer a latch.
    w_state_next     = r_state;
    w_clk_count_next = r_clk_count;
    w_bit_index_next = r_bit_index;
    w_shift_next     = r_shift;
    w_data_next      = r_data;
    w_valid_next     = 1'b0;
    w_frame_err_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_count_next = '0;
        w_bit_index_next = '0;
        if (!w_rx_s) begin
          w_state_next = S_START;
        end
      end

      // Wait half a bit, then confirm the line is still low; a high line
      // here means the falling edge was a glitch and is silently dropped.
      S_START: begin
        if (r_clk_count == LP_HALF_LAST) begin
          w_clk_count_next = '0;
          w_state_next     = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_clk_count_next = r_clk_count + 16'd1;
        end
      end

      // Each sample enters at the MSB and shifts right, so after eight
      // samples the first (LSB) bit has arrived at bit 0.
      S_DATA: begin
        if (r_clk_count == LP_BIT_LAST) begin
          w_clk_count_next = '0;
          w_shift_next     = {w_rx_s, r_shift[7:1]};
          if (r_bit_index == 3'd7) begin
            w_bit_index_next = '0;
            w_state_next     = S_STOP;
          end else begin
            w_bit_index_next = r_bit_index + 3'd1;
          end
        end else begin
          w_clk_count_next = r_clk_count + 16'd1;
        end
      end

      // Returning to IDLE at mid-stop-bit leaves half a bit of margin to
      // catch a following start edge with no idle gap.
      S_STOP: begin
        if (r_clk_count == LP_BIT_LAST) begin
          w_clk_count_next = '0;
          if (w_rx_s) begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err_next = 1'b1;
            w_state_next     = S_WAIT_IDLE;
          end
        end else begin
          w_clk_count_next = r_clk_count + 16'd1;
        end
      end

      // A held-low line (break) must not be read as a stream of new frames.
      S_WAIT_IDLE: begin
        w_clk_count_next = '0;
        if (w_rx_s) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next     = S_IDLE;
        w_clk_count_next = '0;
        w_bit_index_next = '0;
      end
    endcase
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = (r_state != S_IDLE);

endmodule
